// File: rtl/cpm_reg_master.sv
// CPM register-bus initiator: accepts one host command at a time (write, read or
// poll-until-match), runs it over the req/gnt port and returns exactly one response.
module cpm_reg_master #(
    parameter int unsigned POLL_MAX = 16,  // reads per poll before timeout, >= 1
    parameter int unsigned POLL_GAP = 4    // req-low cycles between poll reads
) (
    input  logic        clk,
    input  logic        rst_n,
    // Command channel
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic        cmd_poll,
    input  logic [7:0]  cmd_addr,
    input  logic [31:0] cmd_data,
    input  logic [31:0] cmd_mask,
    // Response channel
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_timeout,
    output logic [7:0]  rsp_reads,
    // CPM register bus
    output logic        req,
    input  logic        gnt,
    output logic        write_en,
    output logic [7:0]  addr,
    output logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic        busy
);

    localparam int unsigned PollCntW = $clog2(POLL_MAX + 1);
    localparam int unsigned GapCntW  = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;

    typedef enum logic [1:0] {StIdle, StIssue, StGap, StResp} state_e;

    state_e              state_q;
    logic                poll_q;
    logic [31:0]         cmp_data_q;
    logic [31:0]         cmp_mask_q;
    logic [PollCntW-1:0] poll_cnt_q;
    logic [GapCntW-1:0]  gap_cnt_q;

    logic xfer_done;
    logic poll_match;
    logic poll_last;
    logic [7:0] reads_inc;

    assign xfer_done  = req && gnt;
    assign poll_match = ((rdata & cmp_mask_q) == cmp_data_q);
    // poll_cnt_q counts reads already completed without a match
    assign poll_last  = (poll_cnt_q == PollCntW'(POLL_MAX - 1));
    assign reads_inc  = (rsp_reads == 8'hFF) ? rsp_reads : rsp_reads + 8'd1;

    assign cmd_ready  = (state_q == StIdle);
    assign busy       = (state_q != StIdle);

    // Command sequencer with all bus and response outputs registered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            poll_q      <= 1'b0;
            cmp_data_q  <= '0;
            cmp_mask_q  <= '0;
            poll_cnt_q  <= '0;
            gap_cnt_q   <= '0;
            req         <= 1'b0;
            write_en    <= 1'b0;
            addr        <= '0;
            wdata       <= '0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_timeout <= 1'b0;
            rsp_reads   <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (cmd_valid && cmd_ready) begin
                        addr        <= cmd_addr;
                        write_en    <= cmd_write;
                        wdata       <= cmd_write ? cmd_data : '0;
                        // a poll flag on a write is meaningless; run it as a plain write
                        poll_q      <= cmd_poll && !cmd_write;
                        cmp_data_q  <= cmd_data;
                        cmp_mask_q  <= cmd_mask;
                        poll_cnt_q  <= '0;
                        gap_cnt_q   <= '0;
                        rsp_rdata   <= '0;
                        rsp_timeout <= 1'b0;
                        rsp_reads   <= '0;
                        req         <= 1'b1;
                        state_q     <= StIssue;
                    end
                end
                StIssue: begin
                    if (xfer_done) begin
                        if (write_en) begin
                            req       <= 1'b0;
                            rsp_rdata <= '0;
                            rsp_reads <= '0;
                            rsp_valid <= 1'b1;
                            state_q   <= StResp;
                        end else begin
                            rsp_rdata <= rdata;
                            rsp_reads <= reads_inc;
                            if (!poll_q || poll_match) begin
                                req       <= 1'b0;
                                rsp_valid <= 1'b1;
                                state_q   <= StResp;
                            end else if (poll_last) begin
                                req         <= 1'b0;
                                rsp_timeout <= 1'b1;
                                rsp_valid   <= 1'b1;
                                state_q     <= StResp;
                            end else begin
                                poll_cnt_q <= poll_cnt_q + PollCntW'(1);
                                // zero gap keeps req asserted for the next read
                                if (POLL_GAP != 0) begin
                                    req       <= 1'b0;
                                    gap_cnt_q <= '0;
                                    state_q   <= StGap;
                                end
                            end
                        end
                    end
                end
                StGap: begin
                    if (gap_cnt_q == GapCntW'(POLL_GAP - 1)) begin
                        req     <= 1'b1;
                        state_q <= StIssue;
                    end else begin
                        gap_cnt_q <= gap_cnt_q + GapCntW'(1);
                    end
                end
                StResp: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state_q   <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_cpm_reg_master.sv
// Self-checking bench for cpm_reg_master: directed scenarios plus randomized commands
// checked against a command-level reference model.
module tb_cpm_reg_master;

    localparam int unsigned POLL_MAX = 16;
    localparam int unsigned POLL_GAP = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic        cmd_poll = 1'b0;
    logic [7:0]  cmd_addr = '0;
    logic [31:0] cmd_data = '0;
    logic [31:0] cmd_mask = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_timeout;
    logic [7:0]  rsp_reads;
    logic        req;
    logic        gnt = 1'b0;
    logic        write_en;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata = '0;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;

    cpm_reg_master #(
        .POLL_MAX (POLL_MAX),
        .POLL_GAP (POLL_GAP)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_poll    (cmd_poll),
        .cmd_addr    (cmd_addr),
        .cmd_data    (cmd_data),
        .cmd_mask    (cmd_mask),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_timeout (rsp_timeout),
        .rsp_reads   (rsp_reads),
        .req         (req),
        .gnt         (gnt),
        .write_en    (write_en),
        .addr        (addr),
        .wdata       (wdata),
        .rdata       (rdata),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Bus slave model state: read data per completed read, grant wait length
    logic [31:0] rd_vals [1024];
    int          gnt_wait = 0;

    // Transfer log filled by the monitor
    logic [7:0]  log_addr  [1024];
    logic        log_we    [1024];
    logic [31:0] log_wdata [1024];
    int          log_gap   [1024];
    int cyc = 0, n_xfer = 0, rd_idx = 0, gap_run = 0, done_cnt = 0, req_hi = 0, stab_err = 0;
    logic        hold_valid = 1'b0;
    logic [7:0]  h_addr = '0;
    logic        h_we = 1'b0;
    logic [31:0] h_wdata = '0;

    // Monitor: logs completed transfers, req-low run lengths and held-signal stability
    always @(posedge clk) begin
        cyc++;
        if (req) req_hi++;
        if (req && hold_valid && (addr !== h_addr || write_en !== h_we || wdata !== h_wdata))
            stab_err++;
        hold_valid = req && !gnt;
        h_addr = addr;
        h_we = write_en;
        h_wdata = wdata;
        if (req && gnt) begin
            log_addr[n_xfer % 1024] = addr;
            log_we[n_xfer % 1024] = write_en;
            log_wdata[n_xfer % 1024] = wdata;
            log_gap[n_xfer % 1024] = gap_run;
            if (!write_en) rd_idx++;
            n_xfer++;
            gap_run = 0;
            done_cnt++;
        end else if (!req) begin
            gap_run++;
        end
    end

    // Responder: grants after gnt_wait cycles of req, returns the next queued read value
    int wait_left = 0;
    int seen_done = 0;
    always @(negedge clk) begin
        if (!req || seen_done != done_cnt) begin
            wait_left = gnt_wait;
            seen_done = done_cnt;
        end
        if (req && wait_left == 0) begin
            gnt = 1'b1;
            rdata = rd_vals[rd_idx % 1024];
        end else begin
            gnt = 1'b0;
            rdata = $urandom;
            if (req) wait_left--;
        end
    end

    // Offer one command, wait for its response, hold rsp_ready low rdly cycles
    task automatic do_cmd(input logic w, input logic p, input logic [7:0] a,
                          input logic [31:0] d, input logic [31:0] m, input int rdly,
                          output bit ok, output logic [31:0] r_rdata, output logic r_to,
                          output logic [7:0] r_reads, output int lat, output int unstable);
        int n;
        ok = 1'b1;
        unstable = 0;
        lat = 0;
        r_rdata = '0;
        r_to = 1'b0;
        r_reads = '0;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_poll = p;
        cmd_addr = a;
        cmd_data = d;
        cmd_mask = m;
        n = 0;
        while (!cmd_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            ok = 1'b0;
            cmd_valid = 1'b0;
            return;
        end
        lat = cyc;
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_write = 1'($urandom);
        cmd_poll = 1'($urandom);
        cmd_addr = 8'($urandom);
        cmd_data = $urandom;
        cmd_mask = $urandom;
        n = 0;
        while (!rsp_valid && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (!rsp_valid) begin
            ok = 1'b0;
            return;
        end
        lat = cyc - lat;
        r_rdata = rsp_rdata;
        r_to = rsp_timeout;
        r_reads = rsp_reads;
        for (int i = 0; i < rdly; i++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b1 || rsp_rdata !== r_rdata || rsp_timeout !== r_to ||
                rsp_reads !== r_reads || cmd_ready !== 1'b0)
                unstable++;
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        n_checks++; if (req !== 1'b0) begin n_errors++; $display("FAIL rst_req: got %b want 0", req); end
        n_checks++; if (write_en !== 1'b0) begin n_errors++; $display("FAIL rst_we: got %b want 0", write_en); end
        n_checks++; if (addr !== 8'h0) begin n_errors++; $display("FAIL rst_addr: got %h want 0", addr); end
        n_checks++; if (wdata !== 32'h0) begin n_errors++; $display("FAIL rst_wdata: got %h want 0", wdata); end
        n_checks++; if (rsp_valid !== 1'b0) begin n_errors++; $display("FAIL rst_rsp_valid: got %b want 0", rsp_valid); end
        n_checks++; if (rsp_rdata !== 32'h0 || rsp_timeout !== 1'b0 || rsp_reads !== 8'h0) begin
            n_errors++; $display("FAIL rst_rsp_fields: got %h/%b/%0d want 0/0/0", rsp_rdata, rsp_timeout, rsp_reads); end
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL rst_busy: got %b want 0", busy); end
        n_checks++; if (cmd_ready !== 1'b1) begin n_errors++; $display("FAIL rst_cmd_ready: got %b want 1", cmd_ready); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_write();
        bit ok; logic [31:0] rd; logic to; logic [7:0] nr; int lat, us, base, rh;
        gnt_wait = 0;
        base = n_xfer;
        rh = req_hi;
        do_cmd(1'b1, 1'b0, 8'h00, 32'h1, 32'h0, 0, ok, rd, to, nr, lat, us);
        n_checks++; if (ok !== 1'b1) begin n_errors++; $display("FAIL wr_done: got %b want 1", ok); end
        n_checks++; if (lat != 2) begin n_errors++; $display("FAIL wr_latency: got %0d want 2", lat); end
        n_checks++; if (n_xfer - base != 1) begin n_errors++; $display("FAIL wr_xfers: got %0d want 1", n_xfer - base); end
        n_checks++; if (req_hi - rh != 1) begin n_errors++; $display("FAIL wr_req_cycles: got %0d want 1", req_hi - rh); end
        n_checks++; if (log_addr[base] !== 8'h00 || log_we[base] !== 1'b1 || log_wdata[base] !== 32'h1) begin
            n_errors++; $display("FAIL wr_bus: got %h/%b/%h want 00/1/00000001", log_addr[base], log_we[base], log_wdata[base]); end
        n_checks++; if (nr !== 8'd0 || rd !== 32'h0 || to !== 1'b0) begin
            n_errors++; $display("FAIL wr_rsp: got %0d/%h/%b want 0/0/0", nr, rd, to); end
    endtask

    task automatic test_read();
        bit ok; logic [31:0] rd; logic to; logic [7:0] nr; int lat, us, base;
        gnt_wait = 0;
        base = n_xfer;
        rd_vals[rd_idx % 1024] = 32'h0000_002A;
        do_cmd(1'b0, 1'b0, 8'h14, $urandom, $urandom, 0, ok, rd, to, nr, lat, us);
        n_checks++; if (ok !== 1'b1) begin n_errors++; $display("FAIL rd_done: got %b want 1", ok); end
        n_checks++; if (rd !== 32'h2A) begin n_errors++; $display("FAIL rd_rdata: got %h want 0000002a", rd); end
        n_checks++; if (nr !== 8'd1 || to !== 1'b0) begin n_errors++; $display("FAIL rd_reads: got %0d/%b want 1/0", nr, to); end
        n_checks++; if (n_xfer - base != 1 || log_addr[base] !== 8'h14 || log_we[base] !== 1'b0) begin
            n_errors++; $display("FAIL rd_bus: got n=%0d %h/%b want n=1 14/0", n_xfer - base, log_addr[base], log_we[base]); end
    endtask

    task automatic test_poll_match();
        bit ok; logic [31:0] rd; logic to; logic [7:0] nr; int lat, us, base, rb;
        logic [31:0] last;
        gnt_wait = 0;
        base = n_xfer;
        rb = rd_idx;
        for (int k = 0; k < 3; k++) rd_vals[(rb + k) % 1024] = $urandom | 32'h1;
        last = $urandom & ~32'h1;
        rd_vals[(rb + 3) % 1024] = last;
        do_cmd(1'b0, 1'b1, 8'h10, 32'h0, 32'h1, 0, ok, rd, to, nr, lat, us);
        n_checks++; if (ok !== 1'b1) begin n_errors++; $display("FAIL poll_done: got %b want 1", ok); end
        n_checks++; if (nr !== 8'd4 || to !== 1'b0) begin n_errors++; $display("FAIL poll_reads: got %0d/%b want 4/0", nr, to); end
        n_checks++; if (rd !== last) begin n_errors++; $display("FAIL poll_rdata: got %h want %h", rd, last); end
        n_checks++; if (n_xfer - base != 4) begin n_errors++; $display("FAIL poll_xfers: got %0d want 4", n_xfer - base); end
        for (int k = 1; k < 4; k++) begin
            n_checks++; if (log_gap[(base + k) % 1024] != POLL_GAP) begin
                n_errors++; $display("FAIL poll_gap%0d: got %0d want %0d", k, log_gap[(base + k) % 1024], POLL_GAP); end
        end
        for (int k = 0; k < 4; k++) begin
            n_checks++; if (log_addr[(base + k) % 1024] !== 8'h10 || log_we[(base + k) % 1024] !== 1'b0) begin
                n_errors++; $display("FAIL poll_addr%0d: got %h/%b want 10/0", k, log_addr[(base + k) % 1024], log_we[(base + k) % 1024]); end
        end
    endtask

    task automatic test_poll_timeout();
        bit ok; logic [31:0] rd; logic to; logic [7:0] nr; int lat, us, base, rb;
        gnt_wait = 1;
        base = n_xfer;
        rb = rd_idx;
        for (int k = 0; k < int'(POLL_MAX); k++) rd_vals[(rb + k) % 1024] = $urandom | 32'h1;
        do_cmd(1'b0, 1'b1, 8'h22, 32'h0, 32'h1, 1, ok, rd, to, nr, lat, us);
        n_checks++; if (ok !== 1'b1) begin n_errors++; $display("FAIL tmo_done: got %b want 1", ok); end
        n_checks++; if (to !== 1'b1) begin n_errors++; $display("FAIL tmo_flag: got %b want 1", to); end
        n_checks++; if (nr !== 8'(POLL_MAX)) begin n_errors++; $display("FAIL tmo_reads: got %0d want %0d", nr, POLL_MAX); end
        n_checks++; if (rd !== rd_vals[(rb + int'(POLL_MAX) - 1) % 1024]) begin
            n_errors++; $display("FAIL tmo_rdata: got %h want %h", rd, rd_vals[(rb + int'(POLL_MAX) - 1) % 1024]); end
        n_checks++; if (n_xfer - base != int'(POLL_MAX)) begin n_errors++; $display("FAIL tmo_xfers: got %0d want %0d", n_xfer - base, POLL_MAX); end
    endtask

    task automatic test_stall();
        bit ok; logic [31:0] rd; logic to; logic [7:0] nr; int lat, us, base, se, rh;
        logic [7:0] a; logic [31:0] d;
        gnt_wait = 5;
        a = 8'($urandom);
        d = $urandom;
        base = n_xfer;
        se = stab_err;
        rh = req_hi;
        do_cmd(1'b1, 1'b0, a, d, $urandom, 3, ok, rd, to, nr, lat, us);
        n_checks++; if (ok !== 1'b1) begin n_errors++; $display("FAIL stall_done: got %b want 1", ok); end
        n_checks++; if (lat != 7) begin n_errors++; $display("FAIL stall_latency: got %0d want 7", lat); end
        n_checks++; if (req_hi - rh != 6) begin n_errors++; $display("FAIL stall_req_cycles: got %0d want 6", req_hi - rh); end
        n_checks++; if (stab_err != se) begin n_errors++; $display("FAIL stall_bus_stable: got %0d changes want 0", stab_err - se); end
        n_checks++; if (us != 0) begin n_errors++; $display("FAIL stall_rsp_stable: got %0d changes want 0", us); end
        n_checks++; if (log_addr[base] !== a || log_wdata[base] !== d || log_we[base] !== 1'b1) begin
            n_errors++; $display("FAIL stall_bus: got %h/%h want %h/%h", log_addr[base], log_wdata[base], a, d); end
        rd_vals[rd_idx % 1024] = $urandom;
        se = stab_err;
        d = rd_vals[rd_idx % 1024];
        do_cmd(1'b0, 1'b0, a, $urandom, $urandom, 3, ok, rd, to, nr, lat, us);
        n_checks++; if (ok !== 1'b1 || rd !== d || us != 0 || stab_err != se) begin
            n_errors++; $display("FAIL stall_read: got ok=%b %h us=%0d se=%0d want ok=1 %h us=0 se=0", ok, rd, us, stab_err - se, d); end
    endtask

    task automatic test_back_to_back();
        int hs [2];
        int nh, base;
        bit pending;
        gnt_wait = 0;
        base = n_xfer;
        nh = 0;
        pending = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_poll = 1'b0; cmd_addr = 8'h31; cmd_data = 32'hA5A5_0001;
        for (int i = 0; i < 20 && nh < 2; i++) begin
            if (cmd_valid && cmd_ready) begin
                hs[nh] = cyc;
                nh++;
                pending = 1'b1;
            end
            @(negedge clk);
            if (pending) begin
                pending = 1'b0;
                if (nh == 1) begin cmd_addr = 8'h32; cmd_data = 32'hA5A5_0002; end
                else cmd_valid = 1'b0;
            end
        end
        cmd_valid = 1'b0;
        repeat (4) @(negedge clk);
        rsp_ready = 1'b0;
        n_checks++; if (nh != 2 || hs[1] - hs[0] != 3) begin
            n_errors++; $display("FAIL b2b_spacing: got n=%0d gap=%0d want n=2 gap=3", nh, hs[1] - hs[0]); end
        n_checks++; if (n_xfer - base != 2 || log_addr[(base + 1) % 1024] !== 8'h32 || log_wdata[(base + 1) % 1024] !== 32'hA5A5_0002) begin
            n_errors++; $display("FAIL b2b_second: got n=%0d %h/%h want n=2 32/a5a50002", n_xfer - base, log_addr[(base + 1) % 1024], log_wdata[(base + 1) % 1024]); end
    endtask

    task automatic test_reset_in_gap();
        bit ok; logic [31:0] rd; logic to; logic [7:0] nr; int lat, us, base, n, stray;
        logic [31:0] v;
        gnt_wait = 0;
        base = n_xfer;
        for (int k = 0; k < int'(POLL_MAX); k++) rd_vals[(rd_idx + k) % 1024] = $urandom | 32'h1;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_poll = 1'b1; cmd_addr = 8'h10;
        cmd_data = 32'h0; cmd_mask = 32'h1;
        @(negedge clk);
        cmd_valid = 1'b0;
        n = 0;
        while (!(n_xfer > base && !req && busy) && n < 50) begin
            @(negedge clk);
            n++;
        end
        n_checks++; if (!(n_xfer > base && !req && busy)) begin
            n_errors++; $display("FAIL rstgap_reach: got xfers=%0d req=%b busy=%b want gap state", n_xfer - base, req, busy); end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++; if (req !== 1'b0 || busy !== 1'b0 || rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
            n_errors++; $display("FAIL rstgap_outputs: got req=%b busy=%b rsp=%b rdy=%b want 0/0/0/1", req, busy, rsp_valid, cmd_ready); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        stray = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0 || req !== 1'b0 || busy !== 1'b0) stray++;
        end
        n_checks++; if (stray != 0) begin n_errors++; $display("FAIL rstgap_quiet: got %0d active cycles want 0", stray); end
        v = $urandom;
        rd_vals[rd_idx % 1024] = v;
        do_cmd(1'b0, 1'b0, 8'h44, $urandom, $urandom, 0, ok, rd, to, nr, lat, us);
        n_checks++; if (ok !== 1'b1 || rd !== v || nr !== 8'd1 || to !== 1'b0) begin
            n_errors++; $display("FAIL rstgap_next: got ok=%b %h/%0d/%b want ok=1 %h/1/0", ok, rd, nr, to, v); end
    endtask

    task automatic test_random();
        bit ok; logic [31:0] rd; logic to; logic [7:0] nr; int lat, us, base, rb, se;
        logic w, p, e_to, found; logic [7:0] a; logic [31:0] d, m, e_rd; int e_n, e_reads;
        for (int it = 0; it < 25; it++) begin
            w = ($urandom % 3) == 0;
            p = w ? (($urandom % 4) == 0) : 1'($urandom);
            a = 8'($urandom);
            m = $urandom & 32'h3;
            d = w ? $urandom : (($urandom % 8 == 0) ? (m | 32'h100) : ($urandom & m));
            gnt_wait = int'($urandom % 4);
            base = n_xfer;
            rb = rd_idx;
            se = stab_err;
            for (int k = 0; k < int'(POLL_MAX); k++) rd_vals[(rb + k) % 1024] = $urandom;
            // Reference: command-level outcome from the read-value sequence
            e_to = 1'b0; e_rd = '0; e_n = 1; e_reads = 0;
            if (!w && !p) begin
                e_reads = 1; e_rd = rd_vals[rb % 1024];
            end else if (!w) begin
                found = 1'b0;
                for (int k = 0; k < int'(POLL_MAX); k++)
                    if (!found && (rd_vals[(rb + k) % 1024] & m) == d) begin found = 1'b1; e_n = k + 1; end
                if (!found) begin e_n = int'(POLL_MAX); e_to = 1'b1; end
                e_reads = e_n;
                e_rd = rd_vals[(rb + e_n - 1) % 1024];
            end
            do_cmd(w, p, a, d, m, int'($urandom % 3), ok, rd, to, nr, lat, us);
            n_checks++; if (ok !== 1'b1 || us != 0 || stab_err != se) begin
                n_errors++; $display("FAIL rnd%0d_handshake: got ok=%b us=%0d se=%0d want 1/0/0", it, ok, us, stab_err - se); end
            n_checks++; if (rd !== e_rd || to !== e_to || nr !== 8'(e_reads)) begin
                n_errors++; $display("FAIL rnd%0d_rsp: got %h/%b/%0d want %h/%b/%0d", it, rd, to, nr, e_rd, e_to, e_reads); end
            n_checks++; if (n_xfer - base != e_n) begin
                n_errors++; $display("FAIL rnd%0d_xfers: got %0d want %0d", it, n_xfer - base, e_n); end
            for (int k = 0; k < e_n && k < n_xfer - base; k++) begin
                n_checks++; if (log_addr[(base + k) % 1024] !== a || log_we[(base + k) % 1024] !== w ||
                                (w && log_wdata[(base + k) % 1024] !== d) ||
                                (k > 0 && log_gap[(base + k) % 1024] != POLL_GAP)) begin
                    n_errors++; $display("FAIL rnd%0d_bus%0d: got %h/%b/%h gap=%0d want %h/%b/%h", it, k,
                        log_addr[(base + k) % 1024], log_we[(base + k) % 1024], log_wdata[(base + k) % 1024],
                        log_gap[(base + k) % 1024], a, w, d); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_poll_match();
        test_poll_timeout();
        test_stall();
        test_back_to_back();
        test_reset_in_gap();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
